// File: rtl/pipeline_control.sv
// pipeline_control: control unit for a 5-stage pipeline.
// Decodes the instruction in ID and carries its controls through the
// ID/EX, EX/MEM and MEM/WB stages. Resolves branches in EX, detects
// load-use hazards and selects the forwarding sources for the EX operands.
module pipeline_control #(
   parameter int REGW = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [2:0]      opcode,
   input  logic [1:0]      func,
   input  logic [REGW-1:0] ra_id,
   input  logic [REGW-1:0] rb_id,
   input  logic [REGW-1:0] rw_id,
   input  logic [REGW-1:0] ra_ex,
   input  logic [REGW-1:0] rb_ex,
   input  logic [REGW-1:0] rw_mem,
   input  logic [REGW-1:0] rw_wb,
   input  logic            zero,
   output logic [1:0]      branch,
   output logic [1:0]      ext_sel,
   output logic            rb_sel,
   output logic            opb_sel,
   output logic            alu_func,
   output logic [1:0]      forward_ra,
   output logic [1:0]      forward_rb,
   output logic            wm_en,
   output logic            wd_sel,
   output logic            wr_en,
   output logic            stall,
   output logic            flush
);

   localparam logic [2:0] OP_ALU = 3'b000;
   localparam logic [2:0] OP_LDR = 3'b010;
   localparam logic [2:0] OP_STR = 3'b011;
   localparam logic [2:0] OP_B   = 3'b100;
   localparam logic [2:0] OP_BEQ = 3'b101;

   // Controls held by the ID/EX stage; rw is kept so a load in EX can be
   // compared against the source registers of the instruction in ID.
   typedef struct packed {
      logic            valid;
      logic            opb_sel;
      logic            alu_func;
      logic            wm_en;
      logic            wd_sel;
      logic            wr_en;
      logic            is_ldr;
      logic            is_b;
      logic            is_beq;
      logic [REGW-1:0] rw;
   } idex_t;

   typedef struct packed {
      logic valid;
      logic wm_en;
      logic wd_sel;
      logic wr_en;
   } exmem_t;

   typedef struct packed {
      logic valid;
      logic wd_sel;
      logic wr_en;
   } memwb_t;

   idex_t  dec_s;
   idex_t  idex_d;
   idex_t  idex_q;
   exmem_t exmem_d;
   exmem_t exmem_q;
   memwb_t memwb_d;
   memwb_t memwb_q;

   logic uses_rb_s;
   logic taken_s;
   logic load_use_s;
   logic fwd_mem_ok_s;
   logic fwd_wb_ok_s;

   // Forwarding source for one EX operand: MEM beats WB when both match.
   function automatic logic [1:0] fwd_sel(
      input logic [REGW-1:0] src,
      input logic            mem_ok,
      input logic [REGW-1:0] mem_rw,
      input logic            wb_ok,
      input logic [REGW-1:0] wb_rw
   );
      logic [1:0] sel;
      if (mem_ok && (mem_rw == src)) begin
         sel = 2'b01;
      end else if (wb_ok && (wb_rw == src)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Decode the instruction in ID into its per-stage controls.
   always_comb begin
      dec_s       = '0;
      dec_s.valid = 1'b1;
      dec_s.rw    = rw_id;
      ext_sel     = 2'b00;
      rb_sel      = 1'b0;
      uses_rb_s   = 1'b0;
      case (opcode)
         OP_ALU: begin
            dec_s.opb_sel  = func[1];
            dec_s.alu_func = func[0];
            dec_s.wr_en    = 1'b1;
            uses_rb_s      = ~func[1];
         end
         OP_LDR: begin
            ext_sel        = 2'b01;
            dec_s.opb_sel  = 1'b1;
            dec_s.wd_sel   = 1'b1;
            dec_s.wr_en    = 1'b1;
            dec_s.is_ldr   = 1'b1;
         end
         OP_STR: begin
            ext_sel        = 2'b01;
            rb_sel         = 1'b1;
            dec_s.opb_sel  = 1'b1;
            dec_s.wm_en    = 1'b1;
            uses_rb_s      = 1'b1;
         end
         OP_B: begin
            ext_sel        = 2'b10;
            dec_s.alu_func = 1'b1;
            dec_s.is_b     = 1'b1;
         end
         OP_BEQ: begin
            ext_sel        = 2'b10;
            dec_s.alu_func = 1'b1;
            dec_s.is_beq   = 1'b1;
         end
         default: begin
            dec_s.valid = 1'b1;
         end
      endcase
   end

   // Branch resolution and load-use detection; a taken branch overrides a stall.
   always_comb begin
      taken_s    = idex_q.valid & (idex_q.is_b | (idex_q.is_beq & zero));
      load_use_s = idex_q.valid & idex_q.is_ldr &
                   ((idex_q.rw == ra_id) | ((idex_q.rw == rb_id) & uses_rb_s));
      flush      = taken_s;
      stall      = load_use_s & ~taken_s;
      if (taken_s) begin
         branch = 2'b01;
      end else begin
         branch = 2'b11;
      end
   end

   // Next-state for the control stages: bubble into ID/EX on flush or stall.
   always_comb begin
      if (taken_s || load_use_s) begin
         idex_d = '0;
      end else begin
         idex_d = dec_s;
      end
      exmem_d.valid  = idex_q.valid;
      exmem_d.wm_en  = idex_q.wm_en;
      exmem_d.wd_sel = idex_q.wd_sel;
      exmem_d.wr_en  = idex_q.wr_en;
      memwb_d.valid  = exmem_q.valid;
      memwb_d.wd_sel = exmem_q.wd_sel;
      memwb_d.wr_en  = exmem_q.wr_en;
   end

   // Stage registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   // Forwarding: a load in MEM has no data yet, so only non-load writers forward from MEM.
   always_comb begin
      fwd_mem_ok_s = exmem_q.valid & exmem_q.wr_en & ~exmem_q.wd_sel;
      fwd_wb_ok_s  = memwb_q.valid & memwb_q.wr_en;
      forward_ra   = fwd_sel(ra_ex, fwd_mem_ok_s, rw_mem, fwd_wb_ok_s, rw_wb);
      forward_rb   = fwd_sel(rb_ex, fwd_mem_ok_s, rw_mem, fwd_wb_ok_s, rw_wb);
   end

   assign opb_sel  = idex_q.opb_sel;
   assign alu_func = idex_q.alu_func;
   assign wm_en    = exmem_q.valid & exmem_q.wm_en;
   assign wd_sel   = memwb_q.wd_sel;
   assign wr_en    = memwb_q.valid & memwb_q.wr_en;

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed scenarios plus a randomized run checked
// against an instruction-level model of the pipeline.
module tb_pipeline_control;

   logic       clock;
   logic       reset;
   logic [2:0] opcode;
   logic [1:0] func;
   logic [4:0] ra_id, rb_id, rw_id, ra_ex, rb_ex, rw_mem, rw_wb;
   logic       zero;
   logic [1:0] branch, ext_sel, forward_ra, forward_rb;
   logic       rb_sel, opb_sel, alu_func, wm_en, wd_sel, wr_en, stall, flush;

   pipeline_control #(.REGW(5)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .func(func),
      .ra_id(ra_id), .rb_id(rb_id), .rw_id(rw_id), .ra_ex(ra_ex), .rb_ex(rb_ex),
      .rw_mem(rw_mem), .rw_wb(rw_wb), .zero(zero),
      .branch(branch), .ext_sel(ext_sel), .rb_sel(rb_sel), .opb_sel(opb_sel),
      .alu_func(alu_func), .forward_ra(forward_ra), .forward_rb(forward_rb),
      .wm_en(wm_en), .wd_sel(wd_sel), .wr_en(wr_en), .stall(stall), .flush(flush)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One instruction as the datapath sees it.
   typedef struct packed {
      logic       v;
      logic [2:0] op;
      logic [1:0] fn;
      logic [4:0] ra;
      logic [4:0] rb;
      logic [4:0] rw;
   } ins_t;

   int n_cmp = 0;
   int n_bad = 0;

   ins_t pipe_ex  = '0;
   ins_t pipe_mem = '0;
   ins_t pipe_wb  = '0;
   ins_t cur_id   = '0;
   logic exp_flush, exp_stall, exp_lu;
   logic [15:0] exp_vec;

   function automatic ins_t mk(input logic [2:0] op, input logic [1:0] fn,
                               input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw);
      ins_t r;
      r.v = 1'b1; r.op = op; r.fn = fn; r.ra = ra; r.rb = rb; r.rw = rw;
      return r;
   endfunction

   function automatic logic writes(input ins_t i);
      return i.v && (i.op == 3'd0 || i.op == 3'd2);
   endfunction

   // Drive one cycle's inputs, compute what the spec says the outputs must be, wait to mid-cycle.
   task automatic drive_cycle(input ins_t id, input logic zv);
      logic [1:0] e_br, e_ext, e_fa, e_fb;
      logic e_rbs, e_opb, e_alu, e_wm, e_wd, e_wr, taken;
      cur_id = id;
      opcode = id.op; func = id.fn; ra_id = id.ra; rb_id = id.rb; rw_id = id.rw;
      ra_ex = pipe_ex.ra; rb_ex = pipe_ex.rb; rw_mem = pipe_mem.rw; rw_wb = pipe_wb.rw;
      zero = zv;
      taken  = pipe_ex.v && (pipe_ex.op == 3'd4 || (pipe_ex.op == 3'd5 && zv));
      exp_lu = pipe_ex.v && pipe_ex.op == 3'd2 &&
               (pipe_ex.rw == id.ra ||
                (pipe_ex.rw == id.rb && ((id.op == 3'd0 && !id.fn[1]) || id.op == 3'd3)));
      exp_flush = taken;
      exp_stall = exp_lu && !taken;
      e_br  = taken ? 2'b01 : 2'b11;
      e_ext = (id.op == 3'd2 || id.op == 3'd3) ? 2'b01 :
              (id.op == 3'd4 || id.op == 3'd5) ? 2'b10 : 2'b00;
      e_rbs = (id.op == 3'd3);
      e_opb = pipe_ex.v && ((pipe_ex.op == 3'd0 && pipe_ex.fn[1]) || pipe_ex.op == 3'd2 || pipe_ex.op == 3'd3);
      e_alu = pipe_ex.v && ((pipe_ex.op == 3'd0 && pipe_ex.fn[0]) || pipe_ex.op == 3'd4 || pipe_ex.op == 3'd5);
      e_fa  = (writes(pipe_mem) && pipe_mem.op != 3'd2 && pipe_mem.rw == pipe_ex.ra) ? 2'b01 :
              (writes(pipe_wb) && pipe_wb.rw == pipe_ex.ra) ? 2'b10 : 2'b00;
      e_fb  = (writes(pipe_mem) && pipe_mem.op != 3'd2 && pipe_mem.rw == pipe_ex.rb) ? 2'b01 :
              (writes(pipe_wb) && pipe_wb.rw == pipe_ex.rb) ? 2'b10 : 2'b00;
      e_wm  = pipe_mem.v && pipe_mem.op == 3'd3;
      e_wd  = pipe_wb.v && pipe_wb.op == 3'd2;
      e_wr  = writes(pipe_wb);
      exp_vec = {e_br, e_ext, e_rbs, e_opb, e_alu, e_fa, e_fb, e_wm, e_wd, e_wr, exp_stall, exp_flush};
      @(negedge clock);
   endtask

   // Clock edge: instructions move one stage on; bubbles on flush/stall; reset empties the pipe.
   task automatic advance();
      ins_t bub;
      @(posedge clock);
      #1;
      if (!reset) begin
         pipe_ex = '0; pipe_mem = '0; pipe_wb = '0;
      end else begin
         bub = cur_id; bub.v = 1'b0;
         pipe_wb  = pipe_mem;
         pipe_mem = pipe_ex;
         pipe_ex  = (exp_flush || exp_lu) ? bub : cur_id;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      drive_cycle(mk(3'd7, 2'd0, 5'd0, 5'd0, 5'd0), 1'b0);
      advance();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive_cycle(mk(3'd7, 2'd0, 5'd1, 5'd2, 5'd3), 1'b0);
      advance();
      drive_cycle(mk(3'd7, 2'd0, 5'd1, 5'd2, 5'd3), 1'b0);
      n_cmp++; if (branch !== 2'b11) begin n_bad++; $display("FAIL reset_branch: got %b need 11", branch); end
      n_cmp++; if ({stall, flush} !== 2'b00) begin n_bad++; $display("FAIL reset_hazard: got %b need 00", {stall, flush}); end
      n_cmp++; if ({forward_ra, forward_rb} !== 4'b0000) begin n_bad++; $display("FAIL reset_fwd: got %b need 0000", {forward_ra, forward_rb}); end
      n_cmp++; if ({wm_en, wd_sel, wr_en, opb_sel, alu_func} !== 5'b00000) begin n_bad++; $display("FAIL reset_ctl: got %b need 00000", {wm_en, wd_sel, wr_en, opb_sel, alu_func}); end
      advance();
      reset = 1'b1;
   endtask

   task automatic test_forwarding();
      do_reset();
      drive_cycle(mk(3'd0, 2'b00, 5'd1, 5'd2, 5'd0), 1'b0); advance();
      drive_cycle(mk(3'd0, 2'b10, 5'd0, 5'd9, 5'd1), 1'b0); advance();
      drive_cycle(mk(3'd0, 2'b01, 5'd0, 5'd4, 5'd3), 1'b0);
      n_cmp++; if (forward_ra !== 2'b01) begin n_bad++; $display("FAIL fwd_mem: got %b need 01", forward_ra); end
      n_cmp++; if (opb_sel !== 1'b1) begin n_bad++; $display("FAIL ex_imm_opb: got %b need 1", opb_sel); end
      advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0);
      n_cmp++; if (forward_ra !== 2'b10) begin n_bad++; $display("FAIL fwd_wb: got %b need 10", forward_ra); end
      n_cmp++; if (forward_rb !== 2'b00) begin n_bad++; $display("FAIL fwd_none: got %b need 00", forward_rb); end
      n_cmp++; if (alu_func !== 1'b1) begin n_bad++; $display("FAIL ex_sub: got %b need 1", alu_func); end
      advance();
      // both later stages write the same register: MEM wins
      do_reset();
      drive_cycle(mk(3'd0, 2'b00, 5'd1, 5'd2, 5'd7), 1'b0); advance();
      drive_cycle(mk(3'd0, 2'b00, 5'd3, 5'd4, 5'd7), 1'b0); advance();
      drive_cycle(mk(3'd0, 2'b00, 5'd7, 5'd7, 5'd5), 1'b0); advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0);
      n_cmp++; if ({forward_ra, forward_rb} !== 4'b0101) begin n_bad++; $display("FAIL fwd_prio: got %b need 0101", {forward_ra, forward_rb}); end
      advance();
   endtask

   task automatic test_load_use();
      do_reset();
      drive_cycle(mk(3'd2, 2'b00, 5'd6, 5'd0, 5'd5), 1'b0);
      n_cmp++; if (ext_sel !== 2'b01) begin n_bad++; $display("FAIL ldr_ext: got %b need 01", ext_sel); end
      advance();
      drive_cycle(mk(3'd0, 2'b01, 5'd5, 5'd4, 5'd2), 1'b0);
      n_cmp++; if ({stall, flush} !== 2'b10) begin n_bad++; $display("FAIL lu_stall: got %b need 10", {stall, flush}); end
      advance();
      drive_cycle(mk(3'd0, 2'b01, 5'd5, 5'd4, 5'd2), 1'b0);
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_once: got %b need 0", stall); end
      advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0);
      n_cmp++; if ({forward_ra, wd_sel, wr_en} !== 4'b1011) begin n_bad++; $display("FAIL lu_fwd_wb: got %b need 1011", {forward_ra, wd_sel, wr_en}); end
      advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0);
      n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL lu_bubble_wb: got %b need 0", wr_en); end
      advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0);
      n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL lu_sub_wb: got %b need 1", wr_en); end
      advance();
      // rb only matters for register-operand ALU and STR
      drive_cycle(mk(3'd2, 2'b00, 5'd6, 5'd0, 5'd3), 1'b0); advance();
      drive_cycle(mk(3'd0, 2'b10, 5'd1, 5'd3, 5'd4), 1'b0);
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_imm_rb: got %b need 0", stall); end
      advance();
      drive_cycle(mk(3'd2, 2'b00, 5'd6, 5'd0, 5'd3), 1'b0); advance();
      drive_cycle(mk(3'd3, 2'b00, 5'd1, 5'd3, 5'd0), 1'b0);
      n_cmp++; if ({stall, rb_sel} !== 2'b11) begin n_bad++; $display("FAIL lu_str_rb: got %b need 11", {stall, rb_sel}); end
      advance();
      drive_cycle(mk(3'd3, 2'b00, 5'd1, 5'd3, 5'd0), 1'b0); advance();
   endtask

   task automatic test_branch();
      do_reset();
      drive_cycle(mk(3'd5, 2'b00, 5'd1, 5'd2, 5'd0), 1'b0);
      n_cmp++; if (ext_sel !== 2'b10) begin n_bad++; $display("FAIL br_ext: got %b need 10", ext_sel); end
      advance();
      drive_cycle(mk(3'd0, 2'b00, 5'd1, 5'd2, 5'd3), 1'b1);
      n_cmp++; if ({branch, flush, stall} !== 4'b0110) begin n_bad++; $display("FAIL beq_taken: got %b need 0110", {branch, flush, stall}); end
      advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd1, 5'd2, 5'd4), 1'b0);
      n_cmp++; if ({branch, flush} !== 3'b110) begin n_bad++; $display("FAIL beq_one_cycle: got %b need 110", {branch, flush}); end
      advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0); advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0);
      n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL beq_squash1: got %b need 0", wr_en); end
      advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0);
      n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL beq_squash2: got %b need 0", wr_en); end
      advance();
      // not taken
      do_reset();
      drive_cycle(mk(3'd5, 2'b00, 5'd1, 5'd2, 5'd0), 1'b1); advance();
      drive_cycle(mk(3'd0, 2'b00, 5'd1, 5'd2, 5'd3), 1'b0);
      n_cmp++; if ({branch, flush} !== 3'b110) begin n_bad++; $display("FAIL beq_not_taken: got %b need 110", {branch, flush}); end
      advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0); advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0); advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0);
      n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL beq_nt_wb: got %b need 1", wr_en); end
      advance();
   endtask

   task automatic test_stall_flush();
      do_reset();
      drive_cycle(mk(3'd4, 2'b00, 5'd0, 5'd0, 5'd5), 1'b0); advance();
      drive_cycle(mk(3'd0, 2'b01, 5'd5, 5'd5, 5'd2), 1'b0);
      n_cmp++; if ({branch, flush, stall} !== 4'b0110) begin n_bad++; $display("FAIL b_flush_wins: got %b need 0110", {branch, flush, stall}); end
      advance();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive_cycle(mk(3'd2, 2'b00, 5'd6, 5'd0, 5'd5), 1'b0); advance();
      drive_cycle(mk(3'd0, 2'b01, 5'd5, 5'd4, 5'd2), 1'b0);
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_pre_stall: got %b need 1", stall); end
      reset = 1'b0;
      advance();
      reset = 1'b1;
      drive_cycle(mk(3'd0, 2'b01, 5'd5, 5'd4, 5'd2), 1'b0);
      n_cmp++; if ({branch, stall, flush, forward_ra, forward_rb, wm_en, wr_en} !== 10'b1100000000) begin
         n_bad++; $display("FAIL rst_mid_stall: got %b need 1100000000", {branch, stall, flush, forward_ra, forward_rb, wm_en, wr_en});
      end
      advance();
      drive_cycle(mk(3'd7, 2'b00, 5'd9, 5'd9, 5'd9), 1'b0);
      n_cmp++; if (alu_func !== 1'b1) begin n_bad++; $display("FAIL rst_no_bubble: got %b need 1", alu_func); end
      advance();
   endtask

   task automatic test_random();
      ins_t id;
      logic pf, ps, pr;
      logic [2:0] op;
      logic [15:0] got;
      pf = 1'b0; ps = 1'b0; pr = 1'b1;
      id = '0;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         op = 3'($urandom_range(0, 7));
         if (!pr && pf) begin
            id = mk(3'd7, 2'b00, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         end else if (!(!pr && ps)) begin
            id = mk(op, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         end
         reset = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
         drive_cycle(id, 1'($urandom_range(0, 1)));
         got = {branch, ext_sel, rb_sel, opb_sel, alu_func, forward_ra, forward_rb, wm_en, wd_sel, wr_en, stall, flush};
         n_cmp++;
         if (got !== exp_vec) begin
            n_bad++;
            $display("FAIL random cycle %0d: got %h need %h", i, got, exp_vec);
         end
         pf = exp_flush; ps = exp_stall; pr = !reset;
         advance();
      end
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; opcode = 3'd7; func = 2'd0; zero = 1'b0;
      ra_id = 5'd0; rb_id = 5'd0; rw_id = 5'd0;
      ra_ex = 5'd0; rb_ex = 5'd0; rw_mem = 5'd0; rw_wb = 5'd0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_stall_flush();
      test_reset_mid_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
